// File: rtl/gpio_pkg.sv
// Definitions shared between the GPIO block and its input debounce stage.
// Holds the pin-count limit, the pin-vector type and the acceptance-threshold helper.
package gpio_pkg;

  localparam int unsigned GPIO_MAX_PINS = 32;

  typedef logic [GPIO_MAX_PINS-1:0] gpio_pin_vec_t;

  // A programmed threshold of 0 behaves exactly like a threshold of 1.
  function automatic logic thr_reached(input logic [31:0] cnt_inc, input logic [31:0] thr);
    return cnt_inc >= ((thr == 32'd0) ? 32'd1 : thr);
  endfunction

endpackage

// File: rtl/gpio_debounce_cell.sv
// One pin of the debounce stage: a two-flop synchronizer, a stability counter and the filtered output.
// Sticky glitch flag is built only when GPIO_DEBOUNCE_STAT_EN is defined.
module gpio_debounce_cell
  import gpio_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             tick,
  input  logic             pin_in,
  input  logic             filt_en,
  input  logic [CNT_W-1:0] threshold,
  input  logic             glitch_clr,
  output logic             pin_out,
  output logic             pin_chg,
  output logic             glitch
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_pin_out;
  logic             r_pin_chg;
  logic [CNT_W-1:0] r_cnt;

  logic [CNT_W:0]   w_cnt_inc;
  logic             w_differs;
  logic             w_accept;
  logic             w_glitch_evt;

  // The extra bit keeps cnt+1 from wrapping before it is compared.
  assign w_cnt_inc    = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign w_differs    = r_sync2 ^ r_pin_out;
  assign w_accept     = thr_reached(32'(w_cnt_inc), 32'(threshold));
  assign w_glitch_evt = filt_en & tick & ~w_differs & (r_cnt != '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_pin_out <= 1'b0;
      r_pin_chg <= 1'b0;
      r_cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge values,
      // so r_sync2 takes the old r_sync1 and the synchronizer really is two stages.
      r_sync1   <= pin_in;
      r_sync2   <= r_sync1;
      r_pin_chg <= 1'b0;
      if (!filt_en) begin
        r_cnt <= '0;
        if (w_differs) begin
          r_pin_out <= r_sync2;
          r_pin_chg <= 1'b1;
        end
      end else if (tick) begin
        if (!w_differs) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_pin_out <= r_sync2;
          r_pin_chg <= 1'b1;
          r_cnt     <= '0;
        end else begin
          r_cnt <= w_cnt_inc[CNT_W-1:0];
        end
      end
    end
  end

`ifdef GPIO_DEBOUNCE_STAT_EN
  logic r_glitch;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_glitch <= 1'b0;
    end else if (w_glitch_evt) begin
      r_glitch <= 1'b1;
    end else if (glitch_clr) begin
      r_glitch <= 1'b0;
    end
  end

  assign glitch = r_glitch;
`else
  logic w_unused_stat;
  assign w_unused_stat = glitch_clr ^ w_glitch_evt;
  assign glitch        = 1'b0;
`endif

  assign pin_out = r_pin_out;
  assign pin_chg = r_pin_chg;

endmodule

// File: rtl/gpio_debounce.sv
// Input conditioning for the GPIO block: shared prescaled sample tick feeding NUM_PINS debounce cells.
// Define GPIO_DEBOUNCE_STAT_EN to build the sticky per-pin glitch flags.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_PINS = 8,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned PRESC_W  = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_PINS-1:0] pin_in,
  input  logic [NUM_PINS-1:0] filt_en,
  input  logic [CNT_W-1:0]    threshold,
  input  logic [PRESC_W-1:0]  prescale,
  output logic [NUM_PINS-1:0] pin_out,
  output logic [NUM_PINS-1:0] pin_chg,
  output logic [NUM_PINS-1:0] glitch,
  input  logic [NUM_PINS-1:0] glitch_clr
);

  logic [PRESC_W-1:0] r_pcnt;
  logic               w_tick;

  // Using >= rather than == means a prescale lowered below the running count wraps at once.
  assign w_tick = (r_pcnt >= prescale);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PRESC_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    gpio_debounce_cell #(
      .CNT_W (CNT_W)
    ) u_cell (
      .clk        (clk),
      .n_rst      (n_rst),
      .tick       (w_tick),
      .pin_in     (pin_in[g]),
      .filt_en    (filt_en[g]),
      .threshold  (threshold),
      .glitch_clr (glitch_clr[g]),
      .pin_out    (pin_out[g]),
      .pin_chg    (pin_chg[g]),
      .glitch     (glitch[g])
    );
  end

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce: reset, bypass, filtering, glitch flags, prescaler and mode changes.
// Expected glitch flags follow GPIO_DEBOUNCE_STAT_EN as the design does.
module tb_gpio_debounce;

`ifdef GPIO_DEBOUNCE_STAT_EN
  localparam logic STAT = 1'b1;
`else
  localparam logic STAT = 1'b0;
`endif

  logic        clk;
  logic        n_rst;
  logic [7:0]  pin_in;
  logic [7:0]  filt_en;
  logic [7:0]  threshold;
  logic [15:0] prescale;
  logic [7:0]  pin_out;
  logic [7:0]  pin_chg;
  logic [7:0]  glitch;
  logic [7:0]  glitch_clr;

  int n_cmp  = 0;
  int n_miss = 0;

  gpio_debounce #(
    .NUM_PINS (8),
    .CNT_W    (8),
    .PRESC_W  (16)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .pin_in     (pin_in),
    .filt_en    (filt_en),
    .threshold  (threshold),
    .prescale   (prescale),
    .pin_out    (pin_out),
    .pin_chg    (pin_chg),
    .glitch     (glitch),
    .glitch_clr (glitch_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset, then release with the given pin level already applied.
  task automatic do_reset(input logic [7:0] pins_after);
    n_rst = 1'b0;
    edges(2);
    n_rst  = 1'b1;
    pin_in = pins_after;
  endtask

  initial begin
    n_rst      = 1'b0;
    pin_in     = 8'hFF;
    filt_en    = 8'h00;
    threshold  = 8'd4;
    prescale   = 16'd0;
    glitch_clr = 8'h00;

    // Reset holds everything low even with all pads high.
    edges(3);
    check("rst_pin_out", 32'(pin_out), 32'h00);
    check("rst_pin_chg", 32'(pin_chg), 32'h00);
    check("rst_glitch",  32'(glitch),  32'h00);
    pin_in = 8'h00;
    n_rst  = 1'b1;
    edges(4);
    check("rel_pin_out", 32'(pin_out), 32'h00);

    // Bypass: three edges from pad to output, one-cycle change pulse.
    pin_in = 8'hA5;
    edges(2);
    check("byp_e2_out", 32'(pin_out), 32'h00);
    edges(1);
    check("byp_e3_out", 32'(pin_out), 32'hA5);
    check("byp_e3_chg", 32'(pin_chg), 32'hA5);
    edges(1);
    check("byp_e4_chg", 32'(pin_chg), 32'h00);
    check("byp_e4_out", 32'(pin_out), 32'hA5);

    // Filter, prescale 0, threshold 4: accepted at edge 6.
    filt_en   = 8'hFF;
    threshold = 8'd4;
    prescale  = 16'd0;
    do_reset(8'h00);
    edges(3);
    pin_in = 8'h01;
    edges(5);
    check("flt_e5_out", 32'(pin_out), 32'h00);
    edges(1);
    check("flt_e6_out", 32'(pin_out), 32'h01);
    check("flt_e6_chg", 32'(pin_chg), 32'h01);
    edges(1);
    check("flt_e7_chg", 32'(pin_chg), 32'h00);

    // Glitch: pin1 high for two sample edges only.
    pin_in = 8'h03;
    edges(2);
    pin_in = 8'h01;
    edges(2);
    check("gl_e4_flag", 32'(glitch), 32'h00);
    edges(1);
    check("gl_e5_flag", 32'(glitch), STAT ? 32'h02 : 32'h00);
    edges(4);
    check("gl_out",     32'(pin_out), 32'h01);
    check("gl_chg",     32'(pin_chg), 32'h00);
    check("gl_hold",    32'(glitch), STAT ? 32'h02 : 32'h00);
    glitch_clr = 8'h02;
    edges(1);
    glitch_clr = 8'h00;
    check("gl_clr",     32'(glitch), 32'h00);

    // Prescale 3: ticks on edges 4, 8, ...; threshold 2 accepts on the 2nd tick.
    prescale  = 16'd3;
    threshold = 8'd2;
    do_reset(8'h04);
    edges(7);
    check("ps_e7_out", 32'(pin_out), 32'h00);
    edges(1);
    check("ps_e8_out", 32'(pin_out), 32'h04);
    check("ps_e8_chg", 32'(pin_chg), 32'h04);
    edges(1);
    check("ps_e9_chg", 32'(pin_chg), 32'h00);

    // Drop filter on pin3 with cnt=2: output follows sync on the next edge.
    prescale  = 16'd0;
    threshold = 8'd4;
    do_reset(8'h00);
    edges(3);
    pin_in = 8'h08;
    edges(4);
    check("mid_e4_out", 32'(pin_out), 32'h00);
    filt_en = 8'hF7;
    edges(1);
    check("mid_e5_out", 32'(pin_out), 32'h08);
    check("mid_e5_chg", 32'(pin_chg), 32'h08);

    // Re-enable: count restarts from 0, so a falling edge takes the full 6 edges.
    filt_en = 8'hFF;
    edges(2);
    pin_in = 8'h00;
    edges(5);
    check("ren_e5_out", 32'(pin_out), 32'h08);
    edges(1);
    check("ren_e6_out", 32'(pin_out), 32'h00);

    // Threshold 0 accepts on the first differing tick, like threshold 1.
    threshold = 8'd0;
    edges(2);
    pin_in = 8'h08;
    edges(2);
    check("t0_e2_out", 32'(pin_out), 32'h00);
    edges(1);
    check("t0_e3_out", 32'(pin_out), 32'h08);
    check("t0_e3_chg", 32'(pin_chg), 32'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_miss);
    $finish;
  end

endmodule
